regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the single write port of the MIPS register file (`RegisterWrite`, `writeRegister`, `writeBack`) between two writeback requesters: A (ALU result path) and B (memory-load / multi-cycle unit path). Each requester pushes writes through a valid/ready handshake into its own small FIFO. A round-robin arbiter drains the FIFOs at one register write per cycle. The block sits between the execute/memory stages and the register file, and reports whether a read address has a write still in flight.

## Interface
Parameters:
- `DATA_W`, 32, writeback data width
- `ADDR_W`, 5, register address width
- `DEPTH`, 2, entries per requester FIFO; power of two, ≥2

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `a_valid`  in  1  requester A has a write
- `a_ready`  out  1  A FIFO can accept
- `a_addr`  in  ADDR_W  A destination register
- `a_data`  in  DATA_W  A write value
- `b_valid`, `b_ready`, `b_addr`, `b_data`  same as A, for requester B
- `wr_en`  out  1  register-file write enable, drives `RegisterWrite`
- `wr_addr`  out  ADDR_W  drives `writeRegister`
- `wr_data`  out  DATA_W  drives `writeBack`
- `busy`  out  1  any FIFO non-empty or `wr_en` high
- `rd_addr1`, `rd_addr2`  in  ADDR_W  register-file read addresses being issued
- `rd_pend1`, `rd_pend2`  out  1  a matching write is queued in either FIFO
- `byp_hit1`, `byp_hit2`  out  1  bypass hit; present only with `REGARB_BYPASS_EN`
- `byp_data1`, `byp_data2`  out  DATA_W  bypass data; present only with `REGARB_BYPASS_EN`

## Operation
- A push occurs when `x_valid && x_ready`.
- `x_ready = !full`. Ready does not depend on a same-cycle pop, so a full FIFO refuses a push even while it is being popped.
- Arbitration runs each cycle over the FIFO heads:
  - one FIFO non-empty: grant it;
  - both non-empty: grant the requester not granted last (`last_grant` register).
- `last_grant` updates only on a grant. After reset it is B, so A wins the first contention.
- A grant pops the head and loads the output register on the next edge:
  - `wr_en <= (head_addr != 0)`, `wr_addr <= head_addr`, `wr_data <= head_data`.
- No grant: `wr_en <= 0`; `wr_addr`/`wr_data` hold their values.
- Writes to register 0 are accepted and consume a grant slot, but never assert `wr_en`.
- Order is preserved within each requester. There is no ordering guarantee between A and B.
- `rd_pendN` = 1 when `rd_addrN != 0` and any valid entry in either FIFO has a matching address. This is combinational. The hazard unit uses it to stall.
- Reset mid-operation discards all FIFO contents immediately; no queued write is issued afterwards.

## Timing
- Reset values:
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0;
  - `a_ready`=`b_ready`=1, `busy`=0, `rd_pend*`=0, `byp_hit*`=0;
  - FIFO pointers=0, `last_grant`=B.
- Latency: push at edge N, granted at edge N+1 (head is registered), `wr_en` high in the cycle after edge N+1. Minimum accept-to-write is 2 cycles.
- Throughput: 1 write/cycle aggregate. Under contention, A and B alternate.
- FIFO pointers are ADDR-free counters of log2(DEPTH)+1 bits and wrap modulo 2·DEPTH:
  - full when the pointers differ only in the MSB;
  - empty when equal.
- Push and pop on the same FIFO in the same cycle (not full) are both performed; the count is unchanged.
- `rd_pend*`, `byp_*` and `*_ready` are combinational from registered state and the `rd_addr*` inputs only; there are no valid→ready paths.

## Configuration
- `REGARB_BYPASS_EN` defined: `byp_hitN = wr_en && wr_addr == rd_addrN && rd_addrN != 0`, and `byp_dataN = wr_data` on a hit, else 0. This forwards the write landing this cycle to same-cycle readers of the register file.
- Not defined: the `byp_*` ports are absent and readers see the register file only. `rd_pend*` behaviour is identical in both builds.

## Test plan
- Reset with `rst`=0 while valids are high → all outputs at their reset values; `a_ready`=`b_ready`=1 after release.
- Single A push (addr 5, data 0x0FFFFFFF) at edge 1 → `wr_en`=1, `wr_addr`=5, `wr_data`=0x0FFFFFFF in the cycle after edge 2 only.
- A and B push together for 3 cycles (A: 1,2,3; B: 9,10,11) → `wr_addr` sequence 1,9,2,10,3,11 with no gaps.
- B held valid without grants while A streams, DEPTH=2 → `b_ready` falls after 2 pushes; B entries drain alternately; no data loss.
- A push to addr 0 then addr 7 → one idle slot with `wr_en`=0, then a write to 7; while addr 7 is queued, `rd_addr1`=7 gives `rd_pend1`=1, and `rd_addr1`=0 gives 0.
- With `REGARB_BYPASS_EN`: `rd_addr2` = `wr_addr` = 7 while `wr_en`=1 → `byp_hit2`=1, `byp_data2`=`wr_data`. Assert reset with 2 entries queued → `wr_en` stays 0 after release.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin sharing of the register-file write port between two FIFO-buffered requesters.
// Optional REGARB_BYPASS_EN adds byp_hit*/byp_data* forwarding of the write landing this cycle.
module regarb_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              match1,
  output logic              match2
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  logic [PW-1:0] wp, rp, cnt;
  logic [ADDR_W-1:0] am [DEPTH];
  logic [DATA_W-1:0] dm [DEPTH];
  logic [IW-1:0] idx;
  assign full = (wp ^ rp) == PW'(DEPTH);
  assign empty = wp == rp;
  assign cnt = wp - rp;
  assign head_addr = am[rp[IW-1:0]];
  assign head_data = dm[rp[IW-1:0]];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      am[wp[IW-1:0]] <= in_addr;
      dm[wp[IW-1:0]] <= in_data;
    end
  end
  // Only the occupied window starting at the read pointer is searched.
  always_comb begin
    match1 = 1'b0;
    match2 = 1'b0;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rp[IW-1:0] + IW'(k);
      if (PW'(k) < cnt) begin
        if (am[idx] == rd_addr1) match1 = 1'b1;
        if (am[idx] == rd_addr2) match2 = 1'b1;
      end
    end
  end
endmodule

module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              rd_pend1,
  output logic              rd_pend2
`ifdef REGARB_BYPASS_EN
  ,output logic              byp_hit1,
  output logic              byp_hit2,
  output logic [DATA_W-1:0] byp_data1,
  output logic [DATA_W-1:0] byp_data2
`endif
);
  logic a_full, a_empty, b_full, b_empty, ga, gb, lg;
  logic a_m1, a_m2, b_m1, b_m2;
  logic [ADDR_W-1:0] a_head_addr, b_head_addr, hd_addr;
  logic [DATA_W-1:0] a_head_data, b_head_data, hd_data;
  regarb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_a (
    .clk(clk), .rst(rst), .push(a_valid && !a_full), .pop(ga),
    .in_addr(a_addr), .in_data(a_data), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .full(a_full), .empty(a_empty), .head_addr(a_head_addr), .head_data(a_head_data),
    .match1(a_m1), .match2(a_m2)
  );
  regarb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_b (
    .clk(clk), .rst(rst), .push(b_valid && !b_full), .pop(gb),
    .in_addr(b_addr), .in_data(b_data), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .full(b_full), .empty(b_empty), .head_addr(b_head_addr), .head_data(b_head_data),
    .match1(b_m1), .match2(b_m2)
  );
  assign a_ready = !a_full;
  assign b_ready = !b_full;
  // lg high means B was granted last, so A wins the next contention.
  assign ga = !a_empty && (b_empty || lg);
  assign gb = !b_empty && !ga;
  assign hd_addr = ga ? a_head_addr : b_head_addr;
  assign hd_data = ga ? a_head_data : b_head_data;
  assign busy = !a_empty || !b_empty || wr_en;
  assign rd_pend1 = rd_addr1 != '0 && (a_m1 || b_m1);
  assign rd_pend2 = rd_addr2 != '0 && (a_m2 || b_m2);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      lg <= 1'b1;
    end else if (ga || gb) begin
      wr_en <= hd_addr != '0;
      wr_addr <= hd_addr;
      wr_data <= hd_data;
      lg <= gb;
    end else begin
      wr_en <= 1'b0;
    end
  end
`ifdef REGARB_BYPASS_EN
  assign byp_hit1 = wr_en && wr_addr == rd_addr1 && rd_addr1 != '0;
  assign byp_hit2 = wr_en && wr_addr == rd_addr2 && rd_addr2 != '0;
  assign byp_data1 = byp_hit1 ? wr_data : '0;
  assign byp_data2 = byp_hit2 ? wr_data : '0;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: randomized and directed checks against a queue-level model of the arbiter.
module tb_regfile_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic a_valid, b_valid, a_ready, b_ready, wr_en, busy, rd_pend1, rd_pend2;
  logic [AW-1:0] a_addr, b_addr, wr_addr, rd_addr1, rd_addr2;
  logic [DW-1:0] a_data, b_data, wr_data;
`ifdef REGARB_BYPASS_EN
  logic byp_hit1, byp_hit2;
  logic [DW-1:0] byp_data1, byp_data2;
`endif
  always #5 clk = ~clk;
  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_pend1(rd_pend1), .rd_pend2(rd_pend2)
`ifdef REGARB_BYPASS_EN
    , .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_data1(byp_data1), .byp_data2(byp_data2)
`endif
  );
  logic [AW+DW-1:0] mqa[$], mqb[$];
  bit m_lg;
  logic e_en;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  int n_cmp = 0, n_bad = 0;
  bit run = 1'b0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic bit pend(input logic [AW-1:0] a);
    if (a == '0) return 1'b0;
    foreach (mqa[i]) if (mqa[i][AW+DW-1:DW] == a) return 1'b1;
    foreach (mqb[i]) if (mqb[i][AW+DW-1:DW] == a) return 1'b1;
    return 1'b0;
  endfunction
  task automatic model_clear();
    mqa.delete();
    mqb.delete();
    m_lg = 1'b1;
    e_en = 1'b0;
    e_addr = '0;
    e_data = '0;
  endtask
  task automatic model_edge();
    bit ra, rb, ga, gb;
    logic [AW+DW-1:0] h;
    if (!rst) begin
      model_clear();
      return;
    end
    ra = mqa.size() < DEPTH;
    rb = mqb.size() < DEPTH;
    ga = mqa.size() > 0 && (mqb.size() == 0 || m_lg);
    gb = mqb.size() > 0 && !ga;
    h = '0;
    if (ga) begin h = mqa.pop_front(); m_lg = 1'b0; end
    else if (gb) begin h = mqb.pop_front(); m_lg = 1'b1; end
    if (ga || gb) begin
      e_en = h[AW+DW-1:DW] != '0;
      e_addr = h[AW+DW-1:DW];
      e_data = h[DW-1:0];
    end else e_en = 1'b0;
    if (a_valid && ra) mqa.push_back({a_addr, a_data});
    if (b_valid && rb) mqb.push_back({b_addr, b_data});
  endtask
  always @(negedge clk) if (run) begin
    chk("a_ready", a_ready, mqa.size() < DEPTH);
    chk("b_ready", b_ready, mqb.size() < DEPTH);
    chk("busy", busy, mqa.size() != 0 || mqb.size() != 0 || e_en);
    chk("rd_pend1", rd_pend1, pend(rd_addr1));
    chk("rd_pend2", rd_pend2, pend(rd_addr2));
    chk("wr_en", wr_en, e_en);
    chk("wr_addr", wr_addr, e_addr);
    chk("wr_data", wr_data, e_data);
`ifdef REGARB_BYPASS_EN
    chk("byp_hit1", byp_hit1, e_en && e_addr == rd_addr1 && rd_addr1 != '0);
    chk("byp_hit2", byp_hit2, e_en && e_addr == rd_addr2 && rd_addr2 != '0);
    chk("byp_data1", byp_data1, (e_en && e_addr == rd_addr1 && rd_addr1 != '0) ? e_data : '0);
    chk("byp_data2", byp_data2, (e_en && e_addr == rd_addr2 && rd_addr2 != '0) ? e_data : '0);
`endif
  end
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic drv(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                     input bit bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    model_clear();
    drv(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b1;
  endtask
  initial begin
    int ia, ib, bk;
    bit acc_a, acc_b;
    int ex[6] = '{1, 9, 2, 10, 3, 11};
    logic [AW-1:0] pa[3] = '{5'd1, 5'd2, 5'd3};
    logic [AW-1:0] pb[3] = '{5'd9, 5'd10, 5'd11};
    rd_addr1 = 5'd3;
    rd_addr2 = 5'd4;
    drv(1, 3, 32'h11, 1, 4, 32'h22);
    model_clear();
    run = 1'b1;
    repeat (3) tick();
    chk("reset_wr_en", wr_en, 0);
    chk("reset_busy", busy, 0);
    drv(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("release_a_ready", a_ready, 1);
    chk("release_b_ready", b_ready, 1);
    drv(1, 5, 32'h0FFFFFFF, 0, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    chk("single_e1_wr_en", wr_en, 0);
    tick();
    chk("single_e2_wr_en", wr_en, 1);
    chk("single_e2_wr_addr", wr_addr, 5);
    chk("single_e2_wr_data", wr_data, 32'h0FFFFFFF);
    tick();
    chk("single_e3_wr_en", wr_en, 0);
    do_reset();
    ia = 0; ib = 0;
    for (int k = 0; k < 9; k++) begin
      drv(ia < 3, ia < 3 ? pa[ia] : 5'd0, $urandom, ib < 3, ib < 3 ? pb[ib] : 5'd0, $urandom);
      acc_a = ia < 3 && mqa.size() < DEPTH;
      acc_b = ib < 3 && mqb.size() < DEPTH;
      tick();
      if (acc_a) ia++;
      if (acc_b) ib++;
      if (k >= 1 && k <= 6) begin
        chk("contend_wr_en", wr_en, 1);
        chk("contend_wr_addr", wr_addr, ex[k-1]);
      end
    end
    do_reset();
    bk = 0;
    for (int k = 0; k < 12; k++) begin
      drv(1, 5'(k + 1), $urandom, 1, 5'(20 + bk), $urandom);
      acc_b = mqb.size() < DEPTH;
      tick();
      if (acc_b) bk++;
      if (k == 1) chk("stream_b_ready_low", b_ready, 0);
    end
    drv(0, 0, 0, 0, 0, 0);
    repeat (12) tick();
    chk("stream_drained_busy", busy, 0);
    do_reset();
    drv(1, 0, 32'h1234, 0, 0, 0);
    tick();
    drv(1, 7, 32'hCAFE0007, 0, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    chk("zero_slot_wr_en", wr_en, 0);
    rd_addr1 = 5'd7;
    #1;
    chk("pend_addr7", rd_pend1, 1);
    rd_addr1 = 5'd0;
    #1;
    chk("pend_addr0", rd_pend1, 0);
    tick();
    chk("addr7_wr_en", wr_en, 1);
    chk("addr7_wr_addr", wr_addr, 7);
`ifdef REGARB_BYPASS_EN
    rd_addr2 = 5'd7;
    #1;
    chk("byp_hit2_7", byp_hit2, 1);
    chk("byp_data2_7", byp_data2, 32'hCAFE0007);
`endif
    tick();
    do_reset();
    drv(1, 3, 32'h33, 1, 4, 32'h44);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    model_clear();
    #1;
    chk("midreset_wr_en", wr_en, 0);
    tick();
    tick();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_reset_wr_en", wr_en, 0);
      chk("post_reset_busy", busy, 0);
    end
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b0;
        model_clear();
        tick();
        rst = 1'b1;
      end
      drv($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom);
      rd_addr1 = 5'($urandom_range(0, 7));
      rd_addr2 = 5'($urandom_range(0, 7));
      tick();
    end
    drv(0, 0, 0, 0, 0, 0);
    repeat (8) tick();
    chk("final_idle_busy", busy, 0);
    @(negedge clk);
    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
